// File: rtl/power_operand_feeder_pkg.sv
// Shared definitions for the power-unit operand feeder: FSM encodings,
// the default operand width shared with the power unit, and sizing helpers.
package power_operand_feeder_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } feeder_state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/power_operand_feeder_sync_fifo.sv
// Small synchronous operand FIFO; full/empty come from a registered count so
// a pop in the same cycle never frees a slot for the producer.
module sync_fifo
    import power_operand_feeder_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = countWidth(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/power_operand_feeder.sv
// Feeds buffered operands one at a time to the non-pipelined p**4 unit and
// waits for its result pulse (or a timeout) before issuing the next one.
module power_operand_feeder
    import power_operand_feeder_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] pw_data,
    output logic              pw_valid,
    input  logic              pw_done,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        issued_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT);

    feeder_state_t     r_state;
    logic              r_pwValid;
    logic [DATA_W-1:0] r_pwData;
    logic [TMO_W-1:0]  r_tmoCnt;
    logic              r_timeoutErr;
    logic [7:0]        r_issuedCnt;

    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic [DATA_W-1:0] w_fifoHead;
    logic              w_fifoPop;

    assign w_fifoPop = (r_state == ST_ISSUE);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_fifoPop),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_head  (w_fifoHead)
    );

    // Outputs are registered alongside the state so pw_valid is high exactly
    // while in ISSUE; pw_data is captured from the head as ISSUE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pwValid    <= 1'b0;
            r_pwData     <= '0;
            r_tmoCnt     <= '0;
            r_timeoutErr <= 1'b0;
            r_issuedCnt  <= '0;
        end else begin
            r_pwValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifoEmpty) begin
                        r_state   <= ST_ISSUE;
                        r_pwValid <= 1'b1;
                        r_pwData  <= w_fifoHead;
                    end
                end
                ST_ISSUE: begin
                    r_tmoCnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pw_done) begin
                        r_issuedCnt <= r_issuedCnt + 8'd1;
                        r_state     <= ST_GAP;
                    end else if (r_tmoCnt == TMO_W'(TIMEOUT - 1)) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_tmoCnt <= r_tmoCnt + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = !w_fifoFull;
    assign pw_valid    = r_pwValid;
    assign pw_data     = r_pwData;
    assign busy        = (r_state != ST_IDLE) || !w_fifoEmpty;
    assign timeout_err = r_timeoutErr;
    assign issued_cnt  = r_issuedCnt;

endmodule

// File: tb/tb_power_operand_feeder.sv
// Self-checking bench for power_operand_feeder: directed phases plus a random
// wrap run, checked against a transaction-level model of the feeder.
module tb_power_operand_feeder;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pw_data;
    logic              pw_valid;
    logic              pw_done;
    logic              busy;
    logic              timeout_err;
    logic [7:0]        issued_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: operands queued in the FIFO, and the one outstanding at the unit.
    logic [DATA_W-1:0] modelQ[$];
    bit                outstanding;
    int                since;
    logic [DATA_W-1:0] lastIssued;
    logic [7:0]        expCnt;
    logic              expErr;
    bit                prevValid;
    int                cycle;
    int                lastDoneCycle;
    bit                autoEn;
    int                autoLat;
    bit                manualDone;
    bit                gapDone;
    bit                doneLastCycle;

    always #5 clk = ~clk;

    power_operand_feeder #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pw_data     (pw_data),
        .pw_valid    (pw_valid),
        .pw_done     (pw_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .issued_cnt  (issued_cnt)
    );

    function automatic int pow4(input int p);
        return p * p * p * p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the current cycle, decides pw_done, applies the cycle to the
    // model, then advances to just after the next rising edge.
    task automatic tick();
        int cntBefore;
        bit doneNow;
        cntBefore = modelQ.size();
        checkOutput("in_ready", in_ready, 32'(cntBefore < DEPTH));
        checkOutput("issued_cnt", issued_cnt, expCnt);
        checkOutput("timeout_err", timeout_err, expErr);
        if (pw_valid === 1'b1) begin
            checkOutput("pulse_width", prevValid, 0);
            checkOutput("issue_while_busy", outstanding, 0);
            checkOutput("done_to_issue_gap", 32'((cycle - lastDoneCycle) >= 3), 1);
            checkOutput("queue_nonempty", 32'(modelQ.size() > 0), 1);
            if (modelQ.size() > 0) begin
                checkOutput("pw_data_order", pw_data, modelQ[0]);
                lastIssued  = modelQ.pop_front();
                outstanding = 1'b1;
                since       = 0;
            end
        end else if (outstanding) begin
            checkOutput("pw_data_hold", pw_data, lastIssued);
        end
        prevValid = (pw_valid === 1'b1);

        doneNow = manualDone || (gapDone && doneLastCycle) ||
                  (autoEn && outstanding && since >= autoLat);
        pw_done = doneNow;
        doneLastCycle = 1'b0;

        if (in_valid && cntBefore < DEPTH) begin
            modelQ.push_back(in_data);
        end
        if (outstanding && since >= 1 && doneNow) begin
            expCnt        = expCnt + 8'd1;
            outstanding   = 1'b0;
            lastDoneCycle = cycle;
            doneLastCycle = 1'b1;
        end else if (outstanding && since == TIMEOUT) begin
            expErr      = 1'b1;
            outstanding = 1'b0;
        end else if (outstanding) begin
            since++;
        end

        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data);
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((modelQ.size() != 0 || outstanding) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_budget", 32'(n < budget), 1);
        tick();
        tick();
        checkOutput("busy_idle", busy, 0);
    endtask

    task automatic doReset();
        rst           = 1'b1;
        in_valid      = 1'b0;
        pw_done       = 1'b0;
        manualDone    = 1'b0;
        gapDone       = 1'b0;
        doneLastCycle = 1'b0;
        modelQ.delete();
        outstanding   = 1'b0;
        since         = 0;
        expCnt        = 8'd0;
        expErr        = 1'b0;
        prevValid     = 1'b0;
        lastDoneCycle = -100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pushed;
        int guard;
        logic [DATA_W-1:0] fillData[5];

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        pw_done  = 1'b0;
        autoEn   = 1'b0;
        autoLat  = 1;
        cycle    = 0;
        #1;
        checkOutput("rst_pw_valid", pw_valid, 0);
        checkOutput("rst_pw_data", pw_data, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        checkOutput("rst_issued_cnt", issued_cnt, 0);
        doReset();

        $display("[TB] single operand latency");
        autoEn  = 1'b1;
        autoLat = 3;
        applyStimulus(8'd3);
        checkOutput("lat_t1_valid", pw_valid, 0);
        tick();
        checkOutput("lat_t2_valid", pw_valid, 1);
        checkOutput("lat_t2_data", pw_data, 3);
        checkOutput("p4_result", pow4(int'(pw_data)), 81);
        waitDrain(50);
        checkOutput("single_cnt", issued_cnt, 1);

        $display("[TB] reset mid-WAIT with queued operands");
        autoEn = 1'b0;
        applyStimulus(8'd9);
        applyStimulus(8'd2);
        applyStimulus(8'd3);
        applyStimulus(8'd4);
        tick();
        checkOutput("busy_before_reset", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_pw_valid", pw_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_cnt", issued_cnt, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        doReset();
        repeat (6) tick();

        $display("[TB] fill while stalled");
        autoEn = 1'b0;
        applyStimulus(8'h11);
        tick();
        tick();
        fillData = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = fillData[i];
            tick();
            if (i == 3) begin
                checkOutput("full_in_ready", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        autoEn   = 1'b1;
        autoLat  = 2;
        waitDrain(200);
        checkOutput("fill_cnt", issued_cnt, 5);

        $display("[TB] pw_done gating");
        manualDone = 1'b1;
        tick();
        manualDone = 1'b0;
        tick();
        checkOutput("idle_done_cnt", issued_cnt, 5);
        gapDone = 1'b1;
        applyStimulus(8'h21);
        waitDrain(50);
        gapDone = 1'b0;
        checkOutput("gap_done_cnt", issued_cnt, 6);
        autoLat = TIMEOUT;
        applyStimulus(8'h22);
        waitDrain(80);
        checkOutput("done_at_timeout_err", timeout_err, 0);
        checkOutput("done_at_timeout_cnt", issued_cnt, 7);

        $display("[TB] timeout");
        autoEn = 1'b0;
        applyStimulus(8'h06);
        applyStimulus(8'h07);
        repeat (TIMEOUT + 4) tick();
        autoEn  = 1'b1;
        autoLat = 1;
        waitDrain(60);
        checkOutput("timeout_sticky", timeout_err, 1);
        checkOutput("after_timeout_cnt", issued_cnt, 8);
        applyStimulus(8'h08);
        waitDrain(60);
        checkOutput("timeout_persist", timeout_err, 1);

        $display("[TB] counter and pointer wrap");
        doReset();
        checkOutput("err_cleared", timeout_err, 0);
        autoEn = 1'b1;
        pushed = 0;
        guard  = 0;
        while (pushed < 256 && guard < 20000) begin
            autoLat  = int'($urandom_range(1, 4));
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = DATA_W'($urandom);
            if (in_valid && modelQ.size() < DEPTH) begin
                pushed++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        checkOutput("wrap_push_budget", 32'(guard < 20000), 1);
        waitDrain(500);
        checkOutput("wrap_cnt_zero", issued_cnt, 0);
        checkOutput("wrap_no_error", timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
